convolution_coprocessor_control: RTL

//  Sequencer for the convolution coprocessor: computes y[n] = sum_k h[k]*x[n-k], n = 0..Nx+Nh-2.

---
 rtl/convolution_coprocessor_control_if.sv | 31 +++
 rtl/convolution_coprocessor_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/convolution_coprocessor_control_if.sv
// Host/datapath-side signal bundle of the convolution coprocessor sequencer.
// The slave modport is the sequencer; the master modport is the host/environment.
interface convolution_coprocessor_control_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int SIZE_WIDTH = 6
);
  logic                  start_i;
  logic [SIZE_WIDTH-1:0] size_x_i;
  logic [SIZE_WIDTH-1:0] size_h_i;
  logic [ADDR_WIDTH-1:0] x_addr_o;
  logic [ADDR_WIDTH-1:0] h_addr_o;
  logic                  mac_en_o;
  logic                  mac_clr_o;
  logic                  y_we_o;
  logic [ADDR_WIDTH:0]   y_addr_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport master (
    output start_i, size_x_i, size_h_i,
    input  x_addr_o, h_addr_o, mac_en_o, mac_clr_o, y_we_o, y_addr_o,
           busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, size_x_i, size_h_i,
    output x_addr_o, h_addr_o, mac_en_o, mac_clr_o, y_we_o, y_addr_o,
           busy_o, done_o, err_o
  );
endinterface

// File: rtl/convolution_coprocessor_control.sv
// Convolution sequencer: walks y[n] = sum_k h[k]*x[n-k] over n = 0..Nx+Nh-2,
// issuing H/X read addresses, MAC clear/enable and Y write strobes.
module convolution_coprocessor_control #(
  parameter int ADDR_WIDTH = 5,
  parameter int SIZE_WIDTH = 6
) (
  input logic                            clk,
  input logic                            rst_n,
  convolution_coprocessor_control_if.slave bus
);
  // n and the size registers need one extra bit: n reaches 2*2**ADDR_WIDTH-2
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [SIZE_WIDTH-1:0] MAX_LEN = SIZE_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_FLUSH, S_STORE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0]         n_q, n_d;
  logic [NW-1:0]         nx_q, nx_d;
  logic [NW-1:0]         nh_q, nh_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] kmin_q, kmin_d;
  logic [ADDR_WIDTH-1:0] kmax_q, kmax_d;
  logic                  mac_en_q, mac_en_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  err_q, err_d;

  logic                  sizes_ok;
  logic                  last_n;
  logic                  calc_last;
  logic [NW-1:0]         n_nxt;
  logic [ADDR_WIDTH-1:0] kmin_nxt;
  logic [ADDR_WIDTH-1:0] kmax_nxt;

  assign sizes_ok  = (bus.size_x_i != '0) && (bus.size_x_i <= MAX_LEN) &&
                     (bus.size_h_i != '0) && (bus.size_h_i <= MAX_LEN);
  assign last_n    = (n_q == nx_q + nh_q - NW'(2));
  assign calc_last = (k_q == kmax_q);

  // k range for the next output sample: kmin = max(0, n+1-(Nx-1)), kmax = min(n+1, Nh-1)
  assign n_nxt    = n_q + NW'(1);
  assign kmin_nxt = (n_nxt >= nx_q) ? ADDR_WIDTH'(n_nxt - (nx_q - NW'(1))) : '0;
  assign kmax_nxt = (n_nxt < nh_q - NW'(1)) ? ADDR_WIDTH'(n_nxt)
                                            : ADDR_WIDTH'(nh_q - NW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i && sizes_ok) state_d = S_LOAD;
      S_LOAD:  state_d = S_CALC;
      S_CALC:  if (calc_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_STORE;
      S_STORE: state_d = last_n ? S_DONE : S_CALC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, latched sizes and registered MAC/error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      nx_q      <= '0;
      nh_q      <= '0;
      k_q       <= '0;
      kmin_q    <= '0;
      kmax_q    <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      n_q       <= n_d;
      nx_q      <= nx_d;
      nh_q      <= nh_d;
      k_q       <= k_d;
      kmin_q    <= kmin_d;
      kmax_q    <= kmax_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      err_q     <= err_d;
    end
  end

  // Counter update rules; MAC strobes trail the address issue by one cycle
  // to line up with the registered-read memories.
  always_comb begin
    n_d       = n_q;
    nx_d      = nx_q;
    nh_d      = nh_q;
    k_d       = k_q;
    kmin_d    = kmin_q;
    kmax_d    = kmax_q;
    err_d     = 1'b0;
    mac_en_d  = (state_q == S_CALC);
    mac_clr_d = (state_q == S_CALC) && (k_q == kmin_q);
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (sizes_ok) begin
            nx_d = bus.size_x_i[NW-1:0];
            nh_d = bus.size_h_i[NW-1:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        n_d    = '0;
        k_d    = '0;
        kmin_d = '0;
        kmax_d = '0;
      end
      S_CALC: begin
        if (!calc_last) k_d = k_q + ADDR_WIDTH'(1);
      end
      S_STORE: begin
        if (!last_n) begin
          n_d    = n_nxt;
          kmin_d = kmin_nxt;
          kmax_d = kmax_nxt;
          k_d    = kmin_nxt;
        end
      end
      default: ;
    endcase
  end

  // Output decode: addresses and Y strobe only in their owning states
  always_comb begin
    bus.x_addr_o  = '0;
    bus.h_addr_o  = '0;
    bus.y_we_o    = 1'b0;
    bus.y_addr_o  = '0;
    bus.busy_o    = 1'b0;
    bus.done_o    = 1'b0;
    bus.mac_en_o  = mac_en_q;
    bus.mac_clr_o = mac_clr_q;
    bus.err_o     = err_q;
    case (state_q)
      S_LOAD, S_FLUSH: bus.busy_o = 1'b1;
      S_CALC: begin
        bus.busy_o   = 1'b1;
        bus.h_addr_o = k_q;
        bus.x_addr_o = ADDR_WIDTH'(n_q - NW'(k_q));
      end
      S_STORE: begin
        bus.busy_o   = 1'b1;
        bus.y_we_o   = 1'b1;
        bus.y_addr_o = n_q;
      end
      S_DONE:  bus.done_o = 1'b1;
      default: ;
    endcase
  end
endmodule
